// File: rtl/ysyx_23060075_div_seq_pkg.sv
// Shared definitions for the sequential divider.
//   DIV_DATA_LEN : default operand/result width.
//   div_fixup_t  : sign fix-up flags captured when a request is accepted.
//                  neg_q negates the quotient and neg_r negates the remainder.
package ysyx_23060075_div_seq_pkg;

  localparam int DIV_DATA_LEN = 32;

  typedef struct packed {
    logic neg_q;
    logic neg_r;
  } div_fixup_t;

endpackage

// File: rtl/ysyx_23060075_adder_alu.sv
// Ripple-carry adder/subtractor used by the divider.
//   a, b     : operands (data_len bits)
//   is_sub   : 1 computes a - b, 0 computes a + b
//   result   : sum or difference (data_len bits)
//   carry    : carry out for add; borrow (a < b, unsigned) for subtract
//   overflow : signed overflow of the operation
module ysyx_23060075_adder_alu #(
  parameter int data_len = 32
) (
  input  logic [data_len-1:0] a,
  input  logic [data_len-1:0] b,
  input  logic                is_sub,
  output logic [data_len-1:0] result,
  output logic                carry,
  output logic                overflow
);

  logic [data_len-1:0] b_eff;
  logic [data_len:0]   c;

  // Subtraction is a + ~b + 1, with the +1 fed in as carry-in.
  assign c[0] = is_sub;

  for (genvar gi = 0; gi < data_len; gi++) begin : g_bit
    assign b_eff[gi]  = b[gi] ^ is_sub;
    assign result[gi] = a[gi] ^ b_eff[gi] ^ c[gi];
    assign c[gi+1]    = (a[gi] & b_eff[gi]) | (c[gi] & (a[gi] ^ b_eff[gi]));
  end

  // For subtraction the raw carry-out is "no borrow"; invert it so that
  // carry=1 reports a borrow.
  assign carry    = c[data_len] ^ is_sub;
  assign overflow = (a[data_len-1] == b_eff[data_len-1]) &&
                    (result[data_len-1] != a[data_len-1]);

endmodule

// File: rtl/ysyx_23060075_div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU.
// Produces one quotient bit per cycle through a shared subtractor.
//   clk, rst_n           : clock (rising edge), async active-low reset
//   in_valid / in_ready  : request handshake; in_ready is high only in IDLE
//   a, b, is_signed      : dividend, divisor, signed-operation select
//   out_valid / out_ready: result handshake; results are held until taken
//   quotient, remainder  : registered results
module ysyx_23060075_div_seq
  import ysyx_23060075_div_seq_pkg::*;
#(
  parameter int data_len = DIV_DATA_LEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [data_len-1:0] a,
  input  logic [data_len-1:0] b,
  input  logic                is_signed,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [data_len-1:0] quotient,
  output logic [data_len-1:0] remainder
);

  localparam int CNT_W = $clog2(data_len);
  localparam logic [CNT_W-1:0]    LAST_STEP  = CNT_W'(data_len - 1);
  localparam logic [data_len-1:0] SIGNED_MIN = {1'b1, {(data_len-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_reg;
  logic [data_len-1:0] dividend_reg;   // shifts left; quotient bits enter at LSB
  logic [data_len-1:0] divisor_reg;    // |b|
  logic [data_len-1:0] rem_reg;        // partial remainder R
  logic [CNT_W-1:0]    counter_reg;
  div_fixup_t          fixup_reg;
  logic [data_len-1:0] quotient_reg;
  logic [data_len-1:0] remainder_reg;
  logic                out_valid_reg;

  // Operand capture helpers
  logic                a_neg;
  logic                b_neg;
  logic [data_len-1:0] a_abs;
  logic [data_len-1:0] b_abs;
  logic                b_is_zero;
  logic                signed_ovf;

  always_comb begin
    a_neg      = is_signed & a[data_len-1];
    b_neg      = is_signed & b[data_len-1];
    a_abs      = a_neg ? -a : a;
    b_abs      = b_neg ? -b : b;
    b_is_zero  = (b == '0);
    signed_ovf = is_signed && (a == SIGNED_MIN) && (b == '1);
  end

  // One restoring step. The trial value is data_len+1 bits wide because
  // shifting R left by one can exceed data_len bits before the subtract.
  logic [data_len:0]   trial;
  logic [data_len:0]   adder_b;
  logic [data_len:0]   adder_result;
  logic                borrow;
  logic                overflow_unused;
  logic                diff_msb_unused;
  logic [data_len-1:0] diff;
  logic [data_len-1:0] rem_step;
  logic [data_len-1:0] quot_step;
  logic [data_len-1:0] quot_fixed;
  logic [data_len-1:0] rem_fixed;

  ysyx_23060075_adder_alu #(
    .data_len(data_len + 1)
  ) u_sub (
    .a       (trial),
    .b       (adder_b),
    .is_sub  (1'b1),
    .result  (adder_result),
    .carry   (borrow),
    .overflow(overflow_unused)
  );

  always_comb begin
    trial                     = {rem_reg, dividend_reg[data_len-1]};
    adder_b                   = {1'b0, divisor_reg};
    {diff_msb_unused, diff}   = adder_result;
    // On borrow the trial value is below |b|, so its top bit is zero and
    // the low data_len bits hold it exactly.
    rem_step                  = borrow ? trial[data_len-1:0] : diff;
    quot_step                 = {dividend_reg[data_len-2:0], ~borrow};
    quot_fixed                = fixup_reg.neg_q ? -quot_step : quot_step;
    rem_fixed                 = fixup_reg.neg_r ? -rem_step  : rem_step;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      rem_reg       <= '0;
      counter_reg   <= '0;
      fixup_reg     <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            fixup_reg.neg_q <= a_neg ^ b_neg;
            fixup_reg.neg_r <= a_neg;
            if (b_is_zero) begin
              // Divide by zero: all-ones quotient, raw dividend as remainder
              quotient_reg  <= '1;
              remainder_reg <= a;
              out_valid_reg <= 1'b1;
              state_reg     <= ST_DONE;
            end else if (signed_ovf) begin
              // Most-negative / -1 overflows; result is the dividend itself
              quotient_reg  <= a;
              remainder_reg <= '0;
              out_valid_reg <= 1'b1;
              state_reg     <= ST_DONE;
            end else begin
              dividend_reg <= a_abs;
              divisor_reg  <= b_abs;
              rem_reg      <= '0;
              counter_reg  <= '0;
              state_reg    <= ST_CALC;
            end
          end
        end

        ST_CALC: begin
          dividend_reg <= quot_step;
          rem_reg      <= rem_step;
          counter_reg  <= counter_reg + 1'b1;
          if (counter_reg == LAST_STEP) begin
            quotient_reg  <= quot_fixed;
            remainder_reg <= rem_fixed;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Results stay put until taken; a new request is only looked at
          // once back in IDLE, one cycle later.
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = out_valid_reg;
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;

endmodule
